// File: rtl/simeck_pkg.sv
// Shared definitions for the 5-bit round-constant LFSR and its reverse-order sequencer.
package simeck_pkg;

  localparam int unsigned StateW = 5;
  localparam logic [StateW-1:0] InitDefault = 5'b10011;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPrescan = 2'd1,
    StEmit    = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic logic [StateW-1:0] lfsr5_fwd(input logic [StateW-1:0] s);
    return {s[1] ^ s[0], s[4:1]};
  endfunction

  // Exact inverse of lfsr5_fwd: recovers the predecessor state.
  function automatic logic [StateW-1:0] lfsr5_rev(input logic [StateW-1:0] s);
    return {s[3:0], s[4] ^ s[0]};
  endfunction

endpackage

// File: rtl/lfsr5_bidir.sv
// 5-bit LFSR state register that can load INIT or step forward/backward.
module lfsr5_bidir
  import simeck_pkg::*;
#(
  parameter logic [StateW-1:0] INIT = InitDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              fwd_i,
  input  logic              rev_i,
  output logic [StateW-1:0] s_o
);

  logic [StateW-1:0] s_d, s_q;

  // load wins; the controller never asserts fwd and rev together.
  always_comb begin
    s_d = s_q;
    if (load_i) begin
      s_d = INIT;
    end else if (fwd_i) begin
      s_d = lfsr5_fwd(s_q);
    end else if (rev_i) begin
      s_d = lfsr5_rev(s_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_q <= INIT;
    end else begin
      s_q <= s_d;
    end
  end

  assign s_o = s_q;

endmodule

// File: rtl/lfsr53_rev_seq.sv
// Emits the LFSR round constants in reverse round order: prescan forward, then step backward.
module lfsr53_rev_seq
  import simeck_pkg::*;
#(
  parameter int unsigned       ROUNDS = 32,
  parameter logic [StateW-1:0] INIT   = InitDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       z_ready,
  output logic       z,
  output logic       z_valid,
  output logic [4:0] round_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LastIdx = 5'(ROUNDS - 1);
  // cnt value seen on the (ROUNDS-1)th prescan step.
  localparam logic [4:0] LastCnt = 5'(ROUNDS - 2);

  state_e     state_d, state_q;
  logic [4:0] cnt_d, cnt_q;
  logic [4:0] idx_d, idx_q;
  logic       lfsr_load, lfsr_fwd, lfsr_rev;
  logic [StateW-1:0] s;

  lfsr5_bidir #(
    .INIT(INIT)
  ) u_lfsr (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (lfsr_load),
    .fwd_i  (lfsr_fwd),
    .rev_i  (lfsr_rev),
    .s_o    (s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lfsr_load = 1'b0;
    lfsr_fwd  = 1'b0;
    lfsr_rev  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_load = 1'b1;
          cnt_d     = 5'd0;
          idx_d     = LastIdx;
          state_d   = (ROUNDS == 1) ? StEmit : StPrescan;
        end
      end
      StPrescan: begin
        lfsr_fwd = 1'b1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LastCnt) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (z_ready) begin
          if (idx_q == 5'd0) begin
            state_d = StDone;
          end else begin
            lfsr_rev = 1'b1;
            idx_d    = idx_q - 5'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign z         = s[0];
  assign z_valid   = (state_q == StEmit);
  assign round_idx = idx_q;
  assign busy      = (state_q == StPrescan) || (state_q == StEmit);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_lfsr53_rev_seq.sv
// Randomised-handshake bench for lfsr53_rev_seq over several ROUNDS/INIT configurations.
module tb_lfsr53_rev_seq;

  localparam int NumDut = 4;

  function automatic int unsigned rounds_of(input int i);
    case (i)
      0:       return 32;
      1:       return 1;
      2:       return 7;
      default: return 20;
    endcase
  endfunction

  function automatic logic [4:0] init_of(input int i);
    case (i)
      0:       return 5'b10011;
      1:       return 5'b10011;
      2:       return 5'b00101;
      default: return 5'b11110;
    endcase
  endfunction

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NumDut-1:0] start_r = '0;
  logic [NumDut-1:0] ready_r = '0;
  logic [NumDut-1:0] z_w, zv_w, busy_w, done_w;
  logic [4:0]        idx_w [NumDut];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    lfsr53_rev_seq #(
      .ROUNDS(rounds_of(g)),
      .INIT  (init_of(g))
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .start    (start_r[g]),
      .z_ready  (ready_r[g]),
      .z        (z_w[g]),
      .z_valid  (zv_w[g]),
      .round_idx(idx_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g])
    );
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 ready always, 1 ready alternating, 2 ready random. hold keeps start high all run.
  task automatic run(input int d, input int mode, input bit hold);
    int r;
    logic [4:0] ini;
    bit a[64];
    int cyc;
    int j;
    int guard;
    bit rdy;
    r = rounds_of(d);
    ini = init_of(d);
    // Output stream of the forward LFSR: a[k+5] = a[k+1] ^ a[k].
    for (int k = 0; k < r; k++) a[k] = (k < 5) ? ini[k] : (a[k-4] ^ a[k-5]);
    start_r[d] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) start_r[d] = 1'b0;
    end while (!zv_w[d] && cyc < 40);
    check_eq($sformatf("d%0d latency", d), cyc, r);
    if (!zv_w[d]) begin
      start_r[d] = 1'b0;
      return;
    end
    j = 0;
    guard = 0;
    while (j < r && guard < 400) begin
      check_eq($sformatf("d%0d valid b%0d", d, j), zv_w[d], 1);
      check_eq($sformatf("d%0d idx b%0d", d, j), idx_w[d], r - 1 - j);
      check_eq($sformatf("d%0d z b%0d", d, j), z_w[d], a[r-1-j]);
      check_eq($sformatf("d%0d busy b%0d", d, j), busy_w[d], 1);
      check_eq($sformatf("d%0d early done b%0d", d, j), done_w[d], 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_r[d] = rdy;
      @(posedge clk); #1;
      if (rdy) j++;
      guard++;
    end
    ready_r[d] = 1'b0;
    check_eq($sformatf("d%0d beats", d), j, r);
    check_eq($sformatf("d%0d done pulse", d), done_w[d], 1);
    check_eq($sformatf("d%0d valid in done", d), zv_w[d], 0);
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    check_eq($sformatf("d%0d done cleared", d), done_w[d], 0);
    check_eq($sformatf("d%0d idle busy", d), busy_w[d], 0);
    @(posedge clk); #1;
    check_eq($sformatf("d%0d no rerun", d), busy_w[d], 0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NumDut; d++) begin
      check_eq($sformatf("d%0d rst valid", d), zv_w[d], 0);
      check_eq($sformatf("d%0d rst busy", d), busy_w[d], 0);
      check_eq($sformatf("d%0d rst done", d), done_w[d], 0);
      check_eq($sformatf("d%0d rst idx", d), idx_w[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 0, 1'b1);
    for (int d = 1; d < NumDut; d++) begin
      run(d, 0, 1'b0);
      run(d, 2, 1'b0);
    end
    run(1, 0, 1'b1);

    // Reset on the 10th handshake of a default run.
    start_r[0] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start_r[0] = 1'b0;
    end while (!zv_w[0] && cyc < 40);
    check_eq("mid latency", cyc, 32);
    ready_r[0] = 1'b1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_eq("mid idx before reset", idx_w[0], 22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_r[0] = 1'b0;
    check_eq("mid rst valid", zv_w[0], 0);
    check_eq("mid rst busy", busy_w[0], 0);
    check_eq("mid rst done", done_w[0], 0);
    check_eq("mid rst idx", idx_w[0], 0);
    @(posedge clk); #1;
    check_eq("mid no done", done_w[0], 0);
    check_eq("mid stays idle", busy_w[0], 0);
    run(0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
